// File: rtl/g16_tgt_pkg.sv
// g16_tgt_pkg: shared types and constants for the g16 burst target.
//   g16_tgt_state_e : target burst state (IDLE / WBURST / RBURST)
//   G16_ADR_W       : bus address width; bit G16_WR_BIT selects write
//   G16_DATA_W      : data beat width
//   sat_inc16       : saturating 16-bit increment for the beat counters
package g16_tgt_pkg;
    localparam int G16_ADR_W  = 48;
    localparam int G16_DATA_W = 16;
    localparam int G16_WR_BIT = 47;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WBURST = 2'd1,
        RBURST = 2'd2
    } g16_tgt_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/g16_tgt_mem.sv
// g16_tgt_mem: DEPTH x 16-bit storage for the g16 target window.
//   clk          : clock, rising edge
//   we/waddr/wdata : synchronous write port
//   raddr/rdata  : synchronous read port, rdata registered one cycle after raddr
// Contents are not reset. The target never reads and writes the same word in
// one cycle, so collision behaviour is left undefined.
module g16_tgt_mem
    import g16_tgt_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [G16_DATA_W-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [G16_DATA_W-1:0] rdata
);
    logic [G16_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/g16_target.sv
// g16_target: burst responder for one target port of the g16 arbiter.
// Serves a DEPTH x 16-bit window starting at word address BASE_ADDR.
//   sysClk, rst          : clock, async active-high reset
//   Adr                  : [47]=write, [46:0]=word address (address phase only)
//   dbus_in              : write data, one word per beat
//   tarActive, Clast     : transaction envelope and final-beat marker
//   dataOut              : read data, zero when no valid read beat
//   hit, busy, err       : window decode, burst in progress, sticky error
//   err_clr              : synchronous clear of err (a new error wins)
//   wr_beats, rd_beats   : in-window beat counters
// Optional feature: define G16_TGT_STATS_EN to build the saturating beat
// counters; otherwise wr_beats/rd_beats are tied to zero.
module g16_target
    import g16_tgt_pkg::*;
#(
    parameter logic [46:0] BASE_ADDR = 47'h0,
    parameter int          DEPTH     = 256
) (
    input  logic                  sysClk,
    input  logic                  rst,
    input  logic [G16_ADR_W-1:0]  Adr,
    input  logic [G16_DATA_W-1:0] dbus_in,
    input  logic                  tarActive,
    input  logic                  Clast,
    input  logic                  err_clr,
    output logic [G16_DATA_W-1:0] dataOut,
    output logic                  hit,
    output logic                  busy,
    output logic                  err,
    output logic [15:0]           wr_beats,
    output logic [15:0]           rd_beats
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [46:0] DEPTH_W = 47'(DEPTH);

    g16_tgt_state_e state, state_nxt;

    // ptr carries one extra bit so "past the top" is representable;
    // it saturates at DEPTH instead of wrapping to word 0.
    logic [AW:0]           ptr;
    logic                  hit_q, err_q;
    logic [46:0]           off;
    logic                  adr_hit, addr_ph, beat, abort, ptr_ok;
    logic                  err_set, we, rd_ok;
    logic [AW-1:0]         raddr;
    logic [G16_DATA_W-1:0] rdata;

    assign off     = Adr[46:0] - BASE_ADDR;
    // Below-base addresses wrap to a huge offset; the >= guard keeps them out.
    assign adr_hit = (Adr[46:0] >= BASE_ADDR) && (off < DEPTH_W);
    assign addr_ph = (state == IDLE) && tarActive;
    assign beat    = (state != IDLE) && tarActive;
    assign abort   = (state != IDLE) && !tarActive;
    assign ptr_ok  = !ptr[AW];
    assign err_set = abort || (beat && hit_q && !ptr_ok);
    assign we      = (state == WBURST) && beat && hit_q && ptr_ok;
    assign rd_ok   = (state == RBURST) && beat && hit_q && ptr_ok;

    // Prefetch: the address phase fetches word off so it is registered for
    // beat 0; each read beat fetches the following word.
    assign raddr = (state == IDLE) ? off[AW-1:0] : ptr[AW-1:0] + AW'(1);

    g16_tgt_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (sysClk),
        .we    (we),
        .waddr (ptr[AW-1:0]),
        .wdata (dbus_in),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge sysClk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        dataOut   = '0;
        if (rd_ok) dataOut = rdata;
        unique case (state)
            IDLE:           if (tarActive) state_nxt = Adr[G16_WR_BIT] ? WBURST : RBURST;
            WBURST, RBURST: if (!tarActive || Clast) state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysClk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            hit_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (addr_ph) begin
                ptr   <= off[AW:0];
                hit_q <= adr_hit;
            end else if (beat && ptr_ok) begin
                ptr <= ptr + (AW+1)'(1);
            end
            err_q <= err_set | (err_q & ~err_clr);
        end
    end

    assign hit = hit_q;
    assign err = err_q;

`ifdef G16_TGT_STATS_EN
    logic [15:0] wr_cnt, rd_cnt;

    always_ff @(posedge sysClk or posedge rst) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (we)    wr_cnt <= sat_inc16(wr_cnt);
            if (rd_ok) rd_cnt <= sat_inc16(rd_cnt);
        end
    end

    assign wr_beats = wr_cnt;
    assign rd_beats = rd_cnt;
`else
    assign wr_beats = 16'h0000;
    assign rd_beats = 16'h0000;
`endif
endmodule

// File: tb/tb_g16_target.sv
// tb_g16_target: directed plus randomized bench for g16_target.
// A transaction-level model (window offset + beat index, plain integer
// arithmetic) predicts busy/hit/err/dataOut/counters every cycle; directed
// sections pin the model with literal expectations.
module tb_g16_target;
    localparam logic [46:0] BASE  = 47'h1000;
    localparam int          DEPTH = 16;
`ifdef G16_TGT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        sysClk, rst;
    logic [47:0] Adr;
    logic [15:0] dbus_in;
    logic        tarActive, Clast, err_clr;
    logic [15:0] dataOut, wr_beats, rd_beats;
    logic        hit, busy, err;

    g16_target #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .sysClk(sysClk), .rst(rst), .Adr(Adr), .dbus_in(dbus_in),
        .tarActive(tarActive), .Clast(Clast), .err_clr(err_clr),
        .dataOut(dataOut), .hit(hit), .busy(busy), .err(err),
        .wr_beats(wr_beats), .rd_beats(rd_beats)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    int n_tot = 0, n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit          m_phase = 0, m_wr = 0, m_hit = 0, m_err = 0;
    longint      m_off = 0;
    int          m_k = 0, m_wrc = 0, m_rdc = 0;
    logic [15:0] mem_m [DEPTH];
    bit          mem_v [DEPTH];
    bit          m_set;
    longint      m_a, m_idx;

    always @(posedge sysClk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_hit = 0; m_err = 0; m_wrc = 0; m_rdc = 0;
        end else begin
            m_set = 0;
            if (!m_phase) begin
                if (tarActive) begin
                    m_a     = longint'(Adr[46:0]);
                    m_phase = 1;
                    m_wr    = Adr[47];
                    m_hit   = (m_a >= longint'(BASE)) && (m_a < longint'(BASE) + DEPTH);
                    m_off   = m_a - longint'(BASE);
                    m_k     = 0;
                end
            end else if (tarActive) begin
                m_idx = m_off + m_k;
                if (m_hit) begin
                    if (m_idx < DEPTH) begin
                        if (m_wr) begin
                            mem_m[int'(m_idx)] = dbus_in;
                            mem_v[int'(m_idx)] = 1;
                            if (STATS && m_wrc < 65535) m_wrc++;
                        end else if (STATS && m_rdc < 65535) m_rdc++;
                    end else m_set = 1;
                end
                m_k++;
                if (Clast) m_phase = 0;
            end else begin
                m_phase = 0;
                m_set   = 1;
            end
            m_err = m_set ? 1'b1 : (err_clr ? 1'b0 : m_err);
        end
    end

    longint c_idx;
    always @(negedge sysClk) begin
        if (chk_en) begin
            chk("busy", busy, m_phase);
            chk("hit", hit, m_hit);
            chk("err", err, m_err);
            chk("wr_beats", wr_beats, m_wrc);
            chk("rd_beats", rd_beats, m_rdc);
            c_idx = m_off + m_k;
            if (m_phase && !m_wr && tarActive && m_hit && c_idx < DEPTH) begin
                if (mem_v[int'(c_idx)]) chk("dataOut", dataOut, mem_m[int'(c_idx)]);
            end else chk("dataOut_zero", dataOut, 0);
        end
    end

    // ---------------- drivers ----------------
    logic [15:0] s_data;
    logic        s_busy, s_hit, s_err, s_ap_err, s_ap_busy;
    logic [15:0] s_rd [8];
    logic        s_er [8], s_ht [8], s_bs [8];

    task automatic cyc(input bit ta, input logic [47:0] a, input logic [15:0] d,
                       input bit cl, input bit ec);
        tarActive = ta; Adr = a; dbus_in = d; Clast = cl; err_clr = ec;
        @(negedge sysClk);
        s_data = dataOut; s_busy = busy; s_hit = hit; s_err = err;
        @(posedge sysClk);
        #1;
    endtask

    task automatic burst(input bit wr, input logic [46:0] a, input int n, input logic [15:0] d0);
        cyc(1'b1, {wr, a}, 16'h0, 1'b0, 1'b0);
        s_ap_err = s_err; s_ap_busy = s_busy;
        for (int k = 0; k < n; k++) begin
            cyc(1'b1, 48'h0, d0 + 16'(k), k == n - 1, 1'b0);
            s_rd[k] = s_data; s_er[k] = s_err; s_ht[k] = s_hit; s_bs[k] = s_busy;
        end
    endtask

    task automatic idle(input bit ec);
        cyc(1'b0, 48'h0, 16'h0, 1'b0, ec);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; Adr = '0; dbus_in = '0; tarActive = 0; Clast = 0; err_clr = 0;
        repeat (2) @(posedge sysClk);
        #1;
        chk("rst_busy", busy, 0); chk("rst_hit", hit, 0); chk("rst_err", err, 0);
        chk("rst_data", dataOut, 0); chk("rst_wrb", wr_beats, 0); chk("rst_rdb", rd_beats, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // stats: 3 writes + 5 reads inside the window
        burst(1'b1, BASE, 3, 16'h5000);
        burst(1'b0, BASE, 5, 16'h0);
        idle(1'b0);
        for (int k = 0; k < 3; k++) chk("stat_rd", s_rd[k], 16'h5000 + k);
        chk("stat_wr_beats", wr_beats, STATS ? 3 : 0);
        chk("stat_rd_beats", rd_beats, STATS ? 5 : 0);

        // 4-beat write then read at BASE+8
        burst(1'b1, BASE + 47'd8, 4, 16'hA000);
        burst(1'b0, BASE + 47'd8, 4, 16'h0);
        for (int k = 0; k < 4; k++) chk("t1_rd", s_rd[k], 16'hA000 + k);
        idle(1'b0);
        chk("t1_after_zero", s_data, 0);

        // write across the window top
        burst(1'b1, BASE + 47'(DEPTH - 2), 4, 16'hB000);
        chk("t2_err_beat2", s_er[2], 0);
        chk("t2_err_beat3", s_er[3], 1);
        idle(1'b1);
        chk("t2_err_held", s_err, 1);
        idle(1'b0);
        chk("t2_err_clr", s_err, 0);
        burst(1'b0, BASE + 47'(DEPTH - 2), 2, 16'h0);
        chk("t2_rd0", s_rd[0], 16'hB000);
        chk("t2_rd1", s_rd[1], 16'hB001);
        burst(1'b0, BASE, 1, 16'h0);
        chk("t2_no_wrap", s_rd[0], 16'h5000);

        // miss below the window
        burst(1'b0, BASE - 47'd1, 3, 16'h0);
        for (int k = 0; k < 3; k++) begin
            chk("t3_hit", s_ht[k], 0); chk("t3_data", s_rd[k], 0);
            chk("t3_busy", s_bs[k], 1); chk("t3_err", s_er[k], 0);
        end
        idle(1'b0);
        chk("t3_idle_busy", s_busy, 0);

        // abort after two write beats, next address phase right away
        cyc(1'b1, {1'b1, BASE + 47'd2}, 16'h0, 1'b0, 1'b0);
        cyc(1'b1, 48'h0, 16'hD000, 1'b0, 1'b0);
        cyc(1'b1, 48'h0, 16'hD001, 1'b0, 1'b0);
        idle(1'b0);
        chk("t4_abort_busy", s_busy, 1);
        burst(1'b0, BASE + 47'd2, 2, 16'h0);
        chk("t4_err", s_ap_err, 1);
        chk("t4_idle", s_ap_busy, 0);
        chk("t4_rd0", s_rd[0], 16'hD000);
        chk("t4_rd1", s_rd[1], 16'hD001);
        idle(1'b1);

        // back-to-back write then read, then reset mid-read
        cyc(1'b1, {1'b1, BASE + 47'd5}, 16'h0, 1'b0, 1'b0);
        cyc(1'b1, 48'h0, 16'hE005, 1'b1, 1'b0);
        cyc(1'b1, {1'b0, BASE + 47'd5}, 16'h0, 1'b0, 1'b0);
        cyc(1'b1, 48'h0, 16'h0, 1'b0, 1'b0);
        chk("t5_b2b", s_data, 16'hE005);
        tarActive = 1'b1; Clast = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_data", dataOut, 0);
        @(posedge sysClk);
        #1 rst = 1'b0;
        idle(1'b0);
        burst(1'b0, BASE + 47'd5, 1, 16'h0);
        chk("t5_mem_kept", s_rd[0], 16'hE005);

        // randomized traffic
        for (int t = 0; t < 400; t++) begin
            bit          wr, ab;
            int          n, gap;
            logic [46:0] a;
            wr = 1'($urandom_range(0, 1));
            a  = BASE - 47'd3 + 47'($urandom_range(0, DEPTH + 5));
            n  = $urandom_range(1, 6);
            ab = ($urandom_range(0, 9) == 0);
            cyc(1'b1, {wr, a}, 16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
            for (int k = 0; k < n; k++)
                cyc(1'b1, 48'($urandom), 16'($urandom), (k == n - 1) && !ab,
                    $urandom_range(0, 7) == 0);
            if (ab) cyc(1'b0, 48'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            gap = $urandom_range(0, 2);
            repeat (gap) cyc(1'b0, 48'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                             $urandom_range(0, 3) == 0);
        end

        idle(1'b0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/g16_target.md
# g16_target

Burst target (responder) for the g16 shared bus: the target-side endpoint that consumes the arbiter's target-facing signals (address, write data, `tarActive`, `Clast`) and returns read data on `dataOut`. It implements a DEPTH × 16-bit memory window at a configurable base word address and supports single- and multi-beat read and write bursts. One instance hangs off each target port of the g16 arbiter.

## Interface
- `BASE_ADDR`, 47'h0, first word address of the window (Adr[46:0] units)
- `DEPTH`, 256, window size in 16-bit words; power of two, 2..65536
- `sysClk`  in  1  bus clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `Adr`  in  48  Adr[47]=1 write / 0 read; Adr[46:0] word address; valid in address phase only
- `dbus_in`  in  16  write data, one word per data beat
- `tarActive`  in  1  high for the whole transaction (address phase + data beats)
- `Clast`  in  1  marks final data beat
- `dataOut`  out  16  read data; 16'h0000 when not returning valid read data
- `hit`  out  1  current/last address phase decoded inside window
- `busy`  out  1  burst in progress (state ≠ IDLE)
- `err`  out  1  sticky: beat past window top, or burst aborted
- `err_clr`  in  1  synchronous clear of `err`
- `wr_beats`, `rd_beats`  out  16 each  beat statistics (see Configuration)

## Operation
- States: IDLE, WBURST, RBURST.
- IDLE, `tarActive`=1: address phase. Latch offset = Adr[46:0]−BASE_ADDR into pointer (width clog2(DEPTH)+1); `hit`=1 iff BASE_ADDR ≤ Adr[46:0] < BASE_ADDR+DEPTH. Adr[47] selects WBURST/RBURST. `Clast` ignored in address phase (no zero-length bursts).
- WBURST, `tarActive`=1: beat; if hit and pointer < DEPTH write `dbus_in` to mem[pointer]; pointer++.
- RBURST, `tarActive`=1: beat; `dataOut` shows mem[pointer]; pointer++, next word prefetched.
- Beat with pointer ≥ DEPTH while hit: write dropped / read returns 0, `err` set. Pointer saturates, never wraps.
- Miss (hit=0): state machine still tracks burst; writes dropped, `dataOut`=0, `err` not set.
- Beat with `Clast`=1 → IDLE next cycle. Next cycle with `tarActive`=1 is a new address phase (back-to-back allowed).
- `tarActive` falls in WBURST/RBURST without `Clast` → abort: IDLE, `err` set; completed beats stay written.
- `Clast` while `tarActive`=0 ignored. `err_clr` and a new error in same cycle: `err` stays 1.

## Timing
- Reset values: state IDLE, `dataOut`=0, `hit`=0, `busy`=0, `err`=0, counters 0. Memory contents not reset.
- Address phase at cycle A; data beat k at cycle A+1+k.
- Write: mem[off+k] updated at end of cycle A+1+k.
- Read: `dataOut`=mem[off+k] registered, valid throughout cycle A+1+k (prefetch launched in cycle A). Returns to 0 the cycle after the `Clast` beat.
- Write at beat cycle t, read address phase at t+1: read returns new data.
- `busy` high from A+1 through the `Clast`/abort cycle.
- `rst` mid-burst: immediate IDLE, outputs to reset values.

## Configuration
- `G16_TGT_STATS_EN` defined: `wr_beats`/`rd_beats` count accepted in-window beats, saturate at 16'hFFFF, cleared only by `rst`.
- Undefined: counters not built; both outputs tied to 16'h0000.

## Structure
- Package `g16_tgt_pkg`: state enum (IDLE/WBURST/RBURST), `G16_ADR_W`=48, `G16_DATA_W`=16, `G16_WR_BIT`=47.
- Sub-module `g16_tgt_mem`: DEPTH×16 array, one sync write port, one sync read port (registered output, read-old-on-collision not required since address differs by design).

## Test plan
- Write 4 beats 16'hA000..16'hA003 at BASE_ADDR+8, then read 4 beats at BASE_ADDR+8 → `dataOut` A000,A001,A002,A003 in cycles A+1..A+4, 0 after.
- Write burst starting at BASE_ADDR+DEPTH−2, 4 beats → first two stored, last two dropped, `err`=1 after beat 3; `err_clr` → `err`=0.
- Read at BASE_ADDR−1 (miss) → `hit`=0, `dataOut`=0 every beat, `err`=0, `busy` tracks burst.
- Write burst, drop `tarActive` after beat 2 without `Clast` → IDLE, `err`=1, beats 0–1 stored; next address phase accepted immediately.
- Back-to-back: write 1 beat with `Clast`, `tarActive` held high, read same address next → read returns written word; assert `rst` during a read burst → `dataOut`=0, `busy`=0 same cycle.
- With `G16_TGT_STATS_EN`: 3 writes + 5 reads in window → `wr_beats`=3, `rd_beats`=5; without macro → both 0.
